// File: rtl/hawk_axi_rd_arb.sv
// AXI4 read arbiter: pm/cm cacheline reads, round-robin, one transaction outstanding.
// Optional R-channel watchdog with DRAIN state, enabled by defining HAWK_RD_ARB_TIMEOUT_EN.
module hawk_axi_rd_arb #(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned DATA_WIDTH     = 512,
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  pm_req_valid,
   output logic                  pm_req_ready,
   input  logic [ADDR_WIDTH-1:0] pm_req_addr,
   output logic                  pm_rsp_valid,
   input  logic                  pm_rsp_ready,
   output logic [DATA_WIDTH-1:0] pm_rsp_data,
   output logic                  pm_rsp_err,
   input  logic                  cm_req_valid,
   output logic                  cm_req_ready,
   input  logic [ADDR_WIDTH-1:0] cm_req_addr,
   output logic                  cm_rsp_valid,
   input  logic                  cm_rsp_ready,
   output logic [DATA_WIDTH-1:0] cm_rsp_data,
   output logic                  cm_rsp_err,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   output logic                  timeout_o
);

`ifdef HAWK_RD_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {StIdle, StAr, StR, StRsp, StDrain} state_e;
`else
   typedef enum logic [1:0] {StIdle, StAr, StR, StRsp} state_e;
`endif

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-7:0]  addr_q;
   logic                   gnt_cm_q;
   logic                   last_cm_q;
   logic [DATA_WIDTH-1:0]  data_q;
   logic                   err_q;
   logic                   pick_cm;
   logic                   grant;
   logic                   r_beat;
   logic                   rsp_hs;
   logic                   tmo_hit;
   logic                   unused_inputs;

   // RID is not checked and the line offset is dropped from the address.
   assign unused_inputs = ^{m_axi_rid, pm_req_addr[5:0], cm_req_addr[5:0]};

   // On a tie, whoever was not served last wins.
   assign pick_cm = cm_req_valid & (~pm_req_valid | ~last_cm_q);
   assign grant   = (state_q == StIdle) & (pm_req_valid | cm_req_valid) & ~rst_i;
   assign r_beat  = (state_q == StR) & m_axi_rvalid;
   assign rsp_hs  = (state_q == StRsp) & (gnt_cm_q ? cm_rsp_ready : pm_rsp_ready);

`ifdef HAWK_RD_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q;
   logic            tmo_q;
   logic            tmo_pulse_q;

   assign tmo_hit = (state_q == StR) & ~m_axi_rvalid & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         tmo_q       <= 1'b0;
         tmo_pulse_q <= 1'b0;
      end else begin
         tmo_pulse_q <= tmo_hit;
         if (state_q == StAr) begin
            cnt_q <= '0;
         end else if (state_q == StR) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (tmo_hit) begin
            tmo_q <= 1'b1;
         end else if (state_q == StDrain) begin
            tmo_q <= 1'b0;
         end
      end
   end

   assign timeout_o = tmo_pulse_q;
`else
   assign tmo_hit = 1'b0;
   // Keeps the parameter referenced while the watchdog is compiled out.
   assign timeout_o = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (grant) state_d = StAr;
         StAr:   if (m_axi_arready) state_d = StR;
         StR:    if (r_beat || tmo_hit) state_d = StRsp;
`ifdef HAWK_RD_ARB_TIMEOUT_EN
         StRsp:   if (rsp_hs) state_d = tmo_q ? StDrain : StIdle;
         StDrain: if (m_axi_rvalid) state_d = StIdle;
`else
         StRsp:  if (rsp_hs) state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pm_req_ready  = grant & ~pick_cm;
      cm_req_ready  = grant & pick_cm;
      m_axi_arvalid = (state_q == StAr);
`ifdef HAWK_RD_ARB_TIMEOUT_EN
      m_axi_rready  = (state_q == StR) | (state_q == StDrain);
`else
      m_axi_rready  = (state_q == StR);
`endif
      pm_rsp_valid  = (state_q == StRsp) & ~gnt_cm_q;
      cm_rsp_valid  = (state_q == StRsp) & gnt_cm_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q    <= '0;
         gnt_cm_q  <= 1'b0;
         last_cm_q <= 1'b1;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         if (grant) begin
            gnt_cm_q <= pick_cm;
            addr_q   <= pick_cm ? cm_req_addr[ADDR_WIDTH-1:6] : pm_req_addr[ADDR_WIDTH-1:6];
         end
         if (r_beat) begin
            data_q <= m_axi_rdata;
            err_q  <= (m_axi_rresp != 2'b00) | ~m_axi_rlast;
         end else if (tmo_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
         end
         if (rsp_hs) begin
            last_cm_q <= gnt_cm_q;
         end
      end
   end

   assign m_axi_araddr  = {addr_q, 6'b0};
   assign m_axi_arid    = ID_WIDTH'(gnt_cm_q);
   assign m_axi_arlen   = 8'd0;
   assign m_axi_arsize  = 3'b110;
   assign m_axi_arburst = 2'b01;
   assign pm_rsp_data   = data_q;
   assign cm_rsp_data   = data_q;
   assign pm_rsp_err    = err_q;
   assign cm_rsp_err    = err_q;

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Bench for hawk_axi_rd_arb: transaction-level model checked every cycle plus directed literals.
// Watchdog scenario runs only when HAWK_RD_ARB_TIMEOUT_EN is defined.
module tb_hawk_axi_rd_arb;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 512;
   localparam int unsigned IW = 4;
   localparam int unsigned TC = 16;
`ifdef HAWK_RD_ARB_TIMEOUT_EN
   localparam bit TmoEn = 1'b1;
`else
   localparam bit TmoEn = 1'b0;
`endif
   localparam int RWait = TmoEn ? 5 : 40;

   localparam logic [DW-1:0] PatA = {16{32'hA5A5_0001}};
   localparam logic [DW-1:0] PatB = {16{32'h5A5A_0002}};
   localparam logic [DW-1:0] PatC = {16{32'h1234_5678}};
   localparam logic [DW-1:0] PatD = {16{32'hCAFE_F00D}};
   localparam logic [DW-1:0] PatE = {16{32'h0BAD_BEEF}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          pm_req_valid = 0, pm_req_ready, pm_rsp_valid, pm_rsp_ready = 0, pm_rsp_err;
   logic          cm_req_valid = 0, cm_req_ready, cm_rsp_valid, cm_rsp_ready = 0, cm_rsp_err;
   logic [AW-1:0] pm_req_addr = '0, cm_req_addr = '0, m_axi_araddr;
   logic [DW-1:0] pm_rsp_data, cm_rsp_data, m_axi_rdata = '0;
   logic          m_axi_arvalid, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rready;
   logic [IW-1:0] m_axi_arid, m_axi_rid = '0;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst, m_axi_rresp = '0;
   logic          m_axi_rlast = 1'b1, timeout_o;

   hawk_axi_rd_arb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TC)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .pm_req_valid(pm_req_valid), .pm_req_ready(pm_req_ready), .pm_req_addr(pm_req_addr),
      .pm_rsp_valid(pm_rsp_valid), .pm_rsp_ready(pm_rsp_ready), .pm_rsp_data(pm_rsp_data),
      .pm_rsp_err(pm_rsp_err),
      .cm_req_valid(cm_req_valid), .cm_req_ready(cm_req_ready), .cm_req_addr(cm_req_addr),
      .cm_rsp_valid(cm_rsp_valid), .cm_rsp_ready(cm_rsp_ready), .cm_rsp_data(cm_rsp_data),
      .cm_rsp_err(cm_rsp_err),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
      .timeout_o(timeout_o)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Transaction model: where the one outstanding read is in its life.
   typedef enum int {PIdle, PAr, PR, PRsp, PDrain} phase_e;
   phase_e        m_ph;
   logic          started = 1'b0;
   logic          m_cm, m_last_cm, m_err, m_tmo, m_tpulse;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_rcyc;
   logic          e_cm_wins, e_grant;

   assign e_cm_wins = cm_req_valid && !(pm_req_valid && m_last_cm);

   always @(posedge clk) begin
      started  <= 1'b1;
      m_tpulse <= 1'b0;
      if (rst) begin
         m_ph <= PIdle; m_last_cm <= 1'b1; m_data <= '0; m_err <= 1'b0;
         m_addr <= '0; m_cm <= 1'b0; m_rcyc <= 0; m_tmo <= 1'b0;
      end else begin
         case (m_ph)
            PIdle: if (pm_req_valid || cm_req_valid) begin
               m_cm   <= e_cm_wins;
               m_addr <= e_cm_wins ? cm_req_addr : pm_req_addr;
               m_ph   <= PAr;
            end
            PAr: if (m_axi_arready) begin
               m_ph   <= PR;
               m_rcyc <= 0;
            end
            PR: if (m_axi_rvalid) begin
               m_data <= m_axi_rdata;
               m_err  <= (m_axi_rresp != 2'b00) || !m_axi_rlast;
               m_tmo  <= 1'b0;
               m_ph   <= PRsp;
            end else if (TmoEn && (m_rcyc + 1 == TC)) begin
               m_data <= '0; m_err <= 1'b1; m_tpulse <= 1'b1; m_tmo <= 1'b1; m_ph <= PRsp;
            end else begin
               m_rcyc <= m_rcyc + 1;
            end
            PRsp: if (m_cm ? cm_rsp_ready : pm_rsp_ready) begin
               m_last_cm <= m_cm;
               m_ph      <= m_tmo ? PDrain : PIdle;
            end
            PDrain: if (m_axi_rvalid) m_ph <= PIdle;
            default: m_ph <= PIdle;
         endcase
      end
   end

   always @(negedge clk) begin
      if (started) begin
         e_grant = (m_ph == PIdle) && !rst && (pm_req_valid || cm_req_valid);
         chk("pm_req_ready", pm_req_ready, e_grant && !e_cm_wins);
         chk("cm_req_ready", cm_req_ready, e_grant && e_cm_wins);
         chk("arvalid", m_axi_arvalid, m_ph == PAr);
         if (m_ph == PAr) begin
            chk("araddr", m_axi_araddr, m_addr & ~64'h3F);
            chk("arid", m_axi_arid, m_cm ? 1 : 0);
            chk("arlen", m_axi_arlen, 0);
            chk("arsize", m_axi_arsize, 6);
            chk("arburst", m_axi_arburst, 1);
         end
         chk("rready", m_axi_rready, (m_ph == PR) || (m_ph == PDrain));
         chk("pm_rsp_valid", pm_rsp_valid, (m_ph == PRsp) && !m_cm);
         chk("cm_rsp_valid", cm_rsp_valid, (m_ph == PRsp) && m_cm);
         chk("pm_rsp_data", pm_rsp_data, m_data);
         chk("cm_rsp_data", cm_rsp_data, m_data);
         chk("pm_rsp_err", pm_rsp_err, m_err);
         chk("cm_rsp_err", cm_rsp_err, m_err);
         chk("timeout_o", timeout_o, m_tpulse);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_arvalid();
      int k = 0;
      while (m_axi_arvalid !== 1'b1 && k < 20) begin
         cyc(1);
         k++;
      end
      tests++;
      if (k >= 20) begin
         fails++;
         $display("FAIL wait_arvalid: got no arvalid in 20 cycles want arvalid");
      end
   endtask

   // Issue one request, serve AR at once and R next cycle; returns in the first RSP cycle.
   task automatic simple_read(input bit cm, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [1:0] resp, input bit last);
      if (cm) begin cm_req_valid = 1; cm_req_addr = a; end
      else    begin pm_req_valid = 1; pm_req_addr = a; end
      cyc(1);
      pm_req_valid = 0; cm_req_valid = 0;
      wait_arvalid();
      m_axi_arready = 1; cyc(1); m_axi_arready = 0;
      m_axi_rvalid = 1; m_axi_rdata = d; m_axi_rresp = resp; m_axi_rlast = last;
      cyc(1);
      m_axi_rvalid = 0; m_axi_rlast = 1;
   endtask

   logic [IW-1:0] arid_log [4];

   initial begin
      #200000;
      $display("FAIL global_watchdog: got still running want finished");
      $fatal(1, "bench stalled");
   end

   initial begin
      cyc(3);
      rst = 0;
      @(negedge clk);
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_pm_rsp_valid", pm_rsp_valid, 0);
      chk("rst_timeout", timeout_o, 0);

      // pm single read, minimum latency
      cyc(1);
      pm_req_valid = 1; pm_req_addr = 64'h1000_0047; pm_rsp_ready = 1; cm_rsp_ready = 1;
      m_axi_arready = 1;
      @(negedge clk); chk("t1_grant_N", pm_req_ready, 1);
      cyc(1); pm_req_valid = 0;
      @(negedge clk);
      chk("t1_arvalid_N1", m_axi_arvalid, 1);
      chk("t1_araddr", m_axi_araddr, 64'h1000_0040);
      chk("t1_arid", m_axi_arid, 0);
      cyc(1); m_axi_rvalid = 1; m_axi_rdata = PatA; m_axi_rresp = 0; m_axi_rlast = 1;
      @(negedge clk); chk("t1_rready_N2", m_axi_rready, 1);
      cyc(1); m_axi_rvalid = 0; m_axi_arready = 0;
      @(negedge clk);
      chk("t1_rsp_valid_N3", pm_rsp_valid, 1);
      chk("t1_rsp_data", pm_rsp_data, PatA);
      chk("t1_rsp_err", pm_rsp_err, 0);
      cyc(1);
      @(negedge clk); chk("t1_rsp_done", pm_rsp_valid, 0);

      // round-robin from reset with both requesters always valid
      cyc(1);
      rst = 1; pm_req_valid = 1; cm_req_valid = 1;
      pm_req_addr = 64'h2000_0000; cm_req_addr = 64'h3000_00BF;
      cyc(2);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         wait_arvalid();
         arid_log[i] = m_axi_arid;
         if (i == 3) begin pm_req_valid = 0; cm_req_valid = 0; end
         m_axi_arready = 1; cyc(1); m_axi_arready = 0;
         m_axi_rvalid = 1; m_axi_rdata = (i[0] ? PatB : PatC); cyc(1);
         m_axi_rvalid = 0; cyc(1);
      end
      chk("t2_arid0", arid_log[0], 0);
      chk("t2_arid1", arid_log[1], 1);
      chk("t2_arid2", arid_log[2], 0);
      chk("t2_arid3", arid_log[3], 1);

      // cm read with SLVERR, then pm read missing RLAST
      simple_read(1, 64'h4000_0001, PatB, 2'b10, 1);
      @(negedge clk);
      chk("t3_cm_rsp_valid", cm_rsp_valid, 1);
      chk("t3_cm_rsp_err", cm_rsp_err, 1);
      chk("t3_pm_rsp_valid", pm_rsp_valid, 0);
      cyc(1);
      simple_read(0, 64'h5000_0040, PatC, 2'b00, 0);
      @(negedge clk);
      chk("t3_nolast_err", pm_rsp_err, 1);
      chk("t3_nolast_data", pm_rsp_data, PatC);
      cyc(1);

      // AR and response backpressure, competing cm request must wait
      pm_rsp_ready = 0; cm_rsp_ready = 0;
      pm_req_valid = 1; pm_req_addr = 64'h6000_1234;
      cyc(1);
      pm_req_valid = 0; cm_req_valid = 1; cm_req_addr = 64'h7000_0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_arvalid_hold", m_axi_arvalid, 1);
         chk("t4_araddr_hold", m_axi_araddr, 64'h6000_1200);
         chk("t4_no_cm_grant", cm_req_ready, 0);
         cyc(1);
      end
      m_axi_arready = 1; cyc(1); m_axi_arready = 0;
      m_axi_rvalid = 1; m_axi_rdata = PatD; cyc(1); m_axi_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_rsp_hold", pm_rsp_valid, 1);
         chk("t4_rsp_data_hold", pm_rsp_data, PatD);
         chk("t4_no_grant", cm_req_ready, 0);
         cyc(1);
      end
      pm_rsp_ready = 1; cm_req_valid = 0;
      cyc(1);
      @(negedge clk);
      chk("t4_withdrawn", cm_req_ready, 0);
      chk("t4_rsp_done", pm_rsp_valid, 0);
      cm_rsp_ready = 1;

      // reset while waiting in R
      cyc(1);
      pm_req_valid = 1; pm_req_addr = 64'h8000_0000;
      cyc(1);
      pm_req_valid = 0;
      wait_arvalid();
      m_axi_arready = 1; cyc(1); m_axi_arready = 0;
      cyc(RWait);
      rst = 1; cyc(1); rst = 0;
      @(negedge clk);
      chk("t5_rready", m_axi_rready, 0);
      chk("t5_arvalid", m_axi_arvalid, 0);
      chk("t5_rsp_valid", pm_rsp_valid, 0);
      chk("t5_rsp_data", pm_rsp_data, 0);
      chk("t5_req_ready", pm_req_ready, 0);
      cyc(1);
      pm_req_valid = 1; cm_req_valid = 1;
      @(negedge clk);
      chk("t5_tie_pm", pm_req_ready, 1);
      chk("t5_tie_cm", cm_req_ready, 0);
      cyc(1);
      pm_req_valid = 0; cm_req_valid = 0;
      wait_arvalid();
      m_axi_arready = 1; cyc(1); m_axi_arready = 0;
      m_axi_rvalid = 1; m_axi_rdata = PatE; cyc(1); m_axi_rvalid = 0;
      cyc(1);

`ifdef HAWK_RD_ARB_TIMEOUT_EN
      begin
         int n = 0;
         int k = 0;
         pm_req_valid = 1; pm_req_addr = 64'h9000_0000;
         cyc(1);
         pm_req_valid = 0;
         wait_arvalid();
         m_axi_arready = 1; cyc(1); m_axi_arready = 0;
         while (k < 100) begin
            @(negedge clk);
            if (timeout_o === 1'b1) break;
            if (m_axi_rready === 1'b1) n++;
            k++;
            cyc(1);
         end
         chk("t6_r_cycles", n, TC);
         chk("t6_rsp_valid", pm_rsp_valid, 1);
         chk("t6_rsp_err", pm_rsp_err, 1);
         chk("t6_rsp_data", pm_rsp_data, 0);
         cyc(1);
         pm_req_valid = 1; pm_req_addr = 64'h9100_0040;
         cyc(8);
         @(negedge clk);
         chk("t6_drain_rready", m_axi_rready, 1);
         chk("t6_drain_no_grant", pm_req_ready, 0);
         cyc(1);
         m_axi_rvalid = 1; m_axi_rdata = PatB;
         cyc(1);
         m_axi_rvalid = 0;
         @(negedge clk); chk("t6_regrant", pm_req_ready, 1);
         cyc(1);
         pm_req_valid = 0;
         wait_arvalid();
         m_axi_arready = 1; cyc(1); m_axi_arready = 0;
         m_axi_rvalid = 1; m_axi_rdata = PatC; cyc(1); m_axi_rvalid = 0;
         @(negedge clk);
         chk("t6_next_data", pm_rsp_data, PatC);
         chk("t6_next_err", pm_rsp_err, 0);
         cyc(1);
      end
`endif

      cyc(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
